// File: rtl/gpr_wb_ctrl.sv
// Write-back controller and long-latency scoreboard for the integer register file.
// Merges LSU and mul/div results onto one write port and stalls issue on hazards.
module gpr_wb_ctrl #(
  parameter int MD_DEPTH   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        id_issue_valid,
  input  logic        id_issue_long,
  input  logic        id_issue_wen,
  input  logic [4:0]  id_issue_rd,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  output logic        id_stall,
  input  logic        LS_WB_reg_ls_valid,
  input  logic        LS_WB_reg_trap_valid,
  input  logic        LS_WB_reg_dest_wen,
  input  logic [4:0]  LS_WB_reg_rd,
  input  logic [63:0] write_data,
  input  logic        md_wb_valid,
  input  logic [4:0]  md_wb_rd,
  input  logic [63:0] md_wb_data,
  output logic        md_wb_ready,
  output logic        lsu_hold,
  output logic        gpr_wen,
  output logic [4:0]  gpr_rd,
  output logic [63:0] gpr_wdata
);

  localparam logic [2:0] DEPTH = 3'(MD_DEPTH);
  localparam logic [3:0] SMAX  = 4'(STARVE_MAX);

  logic        lsu_wr;
  logic        md_acc;
  logic        issue_fire;
  logic        cnt_inc;
  logic        cnt_dec;
  logic [31:1] busy;
  logic [31:1] busy_nxt;
  logic [2:0]  out_cnt;
  logic [2:0]  out_cnt_nxt;
  logic [3:0]  wait_cnt;
  logic [3:0]  wait_cnt_nxt;
  logic        lsu_hold_nxt;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= SMAX) ? SMAX : v + 4'd1;
  endfunction

  // x0 has no scoreboard bit and is never busy.
  function automatic logic reg_busy(input logic [31:1] b, input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    return b[r];
  endfunction

  always_comb begin
    lsu_wr      = LS_WB_reg_ls_valid & ~LS_WB_reg_trap_valid &
                  LS_WB_reg_dest_wen & (LS_WB_reg_rd != 5'd0);
    md_wb_ready = ~lsu_wr & ~flush;
    md_acc      = md_wb_valid & md_wb_ready;
  end

  always_comb begin
    gpr_wen   = 1'b0;
    gpr_rd    = 5'd0;
    gpr_wdata = 64'd0;
    if (lsu_wr) begin
      gpr_wen   = 1'b1;
      gpr_rd    = LS_WB_reg_rd;
      gpr_wdata = write_data;
    end else if (md_acc && (md_wb_rd != 5'd0)) begin
      gpr_wen   = 1'b1;
      gpr_rd    = md_wb_rd;
      gpr_wdata = md_wb_data;
    end
  end

  // Stall decision looks only at registered state; a result accepted this
  // cycle releases its consumers one cycle later.
  always_comb begin
    id_stall = id_issue_valid &
               (reg_busy(busy, id_rs1) |
                reg_busy(busy, id_rs2) |
                (id_issue_wen & reg_busy(busy, id_issue_rd)) |
                (id_issue_long & (out_cnt == DEPTH)));
    issue_fire = id_issue_valid & ~id_stall & ~flush;
    cnt_inc    = issue_fire & id_issue_long;
    cnt_dec    = md_acc;
  end

  always_comb begin
    busy_nxt    = busy;
    out_cnt_nxt = out_cnt;
    if (md_acc && (md_wb_rd != 5'd0))
      busy_nxt[md_wb_rd] = 1'b0;
    // Applied after the clear so a same-register set takes precedence.
    if (cnt_inc && id_issue_wen && (id_issue_rd != 5'd0))
      busy_nxt[id_issue_rd] = 1'b1;
    case ({cnt_inc, cnt_dec})
      2'b10:   out_cnt_nxt = out_cnt + 3'd1;
      2'b01:   out_cnt_nxt = (out_cnt != 3'd0) ? out_cnt - 3'd1 : 3'd0;
      default: out_cnt_nxt = out_cnt;
    endcase
    if (flush) begin
      busy_nxt    = '0;
      out_cnt_nxt = 3'd0;
    end
  end

  always_comb begin
    wait_cnt_nxt = 4'd0;
    lsu_hold_nxt = 1'b0;
    if (!(flush || md_acc || !md_wb_valid))
      wait_cnt_nxt = sat_inc(wait_cnt);
    if (!flush)
      lsu_hold_nxt = (wait_cnt == SMAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      out_cnt  <= 3'd0;
      wait_cnt <= 4'd0;
      lsu_hold <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      out_cnt  <= out_cnt_nxt;
      wait_cnt <= wait_cnt_nxt;
      lsu_hold <= lsu_hold_nxt;
    end
  end

endmodule
